// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller.
//   Owns the program counter. It presents pc to the instruction memory and
//   captures each returned word, together with its pc, into a small prefetch
//   buffer. Decode drains that buffer over a valid/ready handshake.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   start, halt            run control (levels); halt has priority over start
//   redirect_valid/_pc     branch redirect: load pc and flush the buffer
//   imem_addr/imem_instr   memory address (equal to pc) and combinational read data
//   out_valid/ready/instr/pc  buffer head toward decode
//   running                high while in RUN
//   fetch_count            number of words pushed, wraps at 2^16
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        running,
  output logic [15:0] fetch_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [15:0]    fetch_count_q, fetch_count_d;

  logic           push;
  logic           pop;

  logic [31:0]    ent_instr [DEPTH];
  logic [31:0]    ent_pc    [DEPTH];

  // out_valid comes only from the registered count, so out_ready never
  // reaches it combinationally.
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;
  assign imem_addr   = pc_q;
  assign running     = (state_q == RUN);
  assign fetch_count = fetch_count_q;
  assign out_instr   = ent_instr[head_q];
  assign out_pc      = ent_pc[head_q];

  // No fetch in the cycle halt is sampled, so the last push lands one edge
  // before the state leaves RUN. A full buffer may still push when the head
  // is popped in the same cycle, which keeps a steady one word per cycle.
  assign push = (state_q == RUN) && !halt && !redirect_valid &&
                ((count_q < CW'(DEPTH)) || pop);

  // Run-control state machine; redirect never affects it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !halt) state_d = RUN;
      RUN:     if (halt)           state_d = HALTED;
      HALTED:  if (start && !halt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, count and pc update. A pop in a redirect cycle is already
  // consumed by decode; the flush simply empties whatever remains.
  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) begin
        pc_d          = pc_q + 32'd4;
        tail_d        = tail_q + PW'(1);
        fetch_count_d = fetch_count_q + 16'd1;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Buffer storage: one register pair per entry, cleared on reset so the
  // head outputs read zero until the first push.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0] instr_q;
    logic [31:0] pc_q_e;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        instr_q <= '0;
        pc_q_e  <= '0;
      end else if (push && (tail_q == PW'(gi))) begin
        instr_q <= imem_instr;
        pc_q_e  <= pc_q;
      end
    end

    assign ent_instr[gi] = instr_q;
    assign ent_pc[gi]    = pc_q_e;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the 256-word instruction memory. It owns the program counter, drives the memory's word-aligned address, and captures each returned instruction word with its PC into a 2-entry prefetch buffer. The buffer feeds decode over a valid/ready handshake. Branch redirects, start and halt control come from the core's execute/control logic.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2: prefetch buffer entries; must be a power of two and at least 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin or resume fetching (level, sampled each edge).
- halt  in  1  stop issuing fetches (level, sampled each edge).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- imem_addr  out  32  fetch address to the instruction memory; equals pc.
- imem_instr  in  32  memory read data, combinational, same cycle as imem_addr.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  PC of the head instruction.
- running  out  1  high while the state machine is in RUN.
- fetch_count  out  16  number of fetched words; wraps at 2^16.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - HALTED.
- Transitions:
  - IDLE → RUN on start & !halt.
  - RUN → HALTED on halt.
  - HALTED → RUN on start & !halt.
  - No other transitions; halt beats start.
- imem_addr = pc at all times, combinationally from the pc register.
- Push (fetch):
  - Occurs in RUN when !redirect_valid and (count < DEPTH, or a pop occurs this cycle).
  - Writes {pc, imem_instr} at the tail.
  - pc ← pc + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0.
  - fetch_count increments.
- Pop: out_valid & out_ready; head advances.
- Full buffer with a simultaneous pop: the push is still allowed, giving sustained 1 instruction/cycle.
- Redirect (any state):
  - pc ← {redirect_pc[31:2], 2'b00}.
  - Buffer count ← 0.
  - No push that cycle.
  - A pop handshake in the same cycle counts as completed (decode consumed it), then the flush applies.
  - The state is unaffected.
- Redirect together with halt: both take effect (new pc, flush, RUN → HALTED).
- HALTED: no pushes; the buffer keeps draining via pops; pc is held.
- Resuming from HALTED continues at the held pc.
- Buffer entries are never overwritten while valid.
- out_instr/out_pc reflect the head entry storage; they hold their last value when empty.

## Timing
- Reset (asynchronous assert):
  - pc = RESET_PC; state = IDLE; count = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0 (storage cleared).
  - running = 0; fetch_count = 0; imem_addr = RESET_PC.
  - Deassert synchronously to clk externally; reset taken mid-stream discards all buffered entries.
- start sampled at edge E → running = 1 after E.
- First push occurs at E+1 → out_valid = 1 after E+1 (two edges from start).
- Redirect at edge R:
  - out_valid = 0 after R.
  - First target-instruction push at R+1; out_valid = 1 after R+1.
- halt at edge H: the last push is at H−1; running = 0 after H.
- out_valid depends only on registered count; no combinational path from out_ready to out_valid, out_instr or out_pc.
- imem_addr depends only on the pc register.

## Test plan
- Reset and steady stream:
  - Stimulus: memory words 0..3 = 32'h00221820, 32'h8C220000, 32'hAC230000, 32'h10620004; RESET_PC = 0; start pulse; out_ready = 1.
  - Response: out_pc 0,4,8,C on consecutive cycles with matching out_instr; fetch_count = 4 after the fourth push.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles after start.
  - Response: count saturates at 2; pc = 8; out_pc holds 0; no entry is lost; releasing out_ready delivers 0, 4, 8 in order.
- Redirect:
  - Stimulus: while streaming, redirect_valid with redirect_pc = 32'h0000_0013.
  - Response: buffered entries flushed; next out_pc = 32'h10; out_valid low for exactly one cycle.
- Halt/resume:
  - Stimulus: halt in RUN with pc = 0xC; 3 cycles of halt; then start.
  - Response: pc stays 0xC; the buffer drains; running = 0; after start, the next pushed out_pc = 0xC.
- Simultaneous events:
  - Stimulus: start & halt together in IDLE; then redirect & halt together in RUN.
  - Response: state stays IDLE; for the second event, state → HALTED with pc = target and the buffer empty.
- Async reset mid-stream:
  - Stimulus: rst_n low between edges while 2 entries are buffered.
  - Response: out_valid = 0 immediately; pc = RESET_PC; fetch_count = 0.
